// File: rtl/rv32m_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// rv32m_iter_unit_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - datapath width and iteration count
//   - funct3 operation codes (M_CNT)
//   - FSM state encoding
//   - per-operation operand signedness helper
// -----------------------------------------------------------------------------
package rv32m_iter_unit_pkg;

    localparam int RV32M_XLEN  = 32;
    localparam int RV32M_STEPS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic signed_a;   // RS1 treated as two's complement
        logic signed_b;   // RS2 treated as two's complement
    } op_sign_t;

    function automatic op_sign_t op_signs(input m_op_e op);
        op_sign_t s;
        unique case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = '{signed_a: 1'b1, signed_b: 1'b1};
            OP_MULHSU:                       s = '{signed_a: 1'b1, signed_b: 1'b0};
            default:                         s = '{signed_a: 1'b0, signed_b: 1'b0};
        endcase
        return s;
    endfunction

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(input m_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/rv32m_iter_unit_if.sv
// -----------------------------------------------------------------------------
// rv32m_iter_unit_if
// START/READY handshake between the EX stage (master) and the iterative
// multiply/divide unit (slave).
//   START  master->slave  level request for the instruction currently in EX
//   M_CNT  master->slave  funct3 operation code
//   RS1    master->slave  multiplicand / dividend
//   RS2    master->slave  multiplier / divisor
//   OUT    slave->master  result, valid while READY, held afterwards
//   READY  slave->master  one-cycle completion pulse
//   BUSY   slave->master  unit is iterating or fixing up a result
// -----------------------------------------------------------------------------
interface rv32m_iter_unit_if;

    logic        START;
    logic [2:0]  M_CNT;
    logic [31:0] RS1;
    logic [31:0] RS2;
    logic [31:0] OUT;
    logic        READY;
    logic        BUSY;

    modport master (
        output START, M_CNT, RS1, RS2,
        input  OUT, READY, BUSY
    );

    modport slave (
        input  START, M_CNT, RS1, RS2,
        output OUT, READY, BUSY
    );

endinterface

// File: rtl/rv32m_div_step.sv
// -----------------------------------------------------------------------------
// rv32m_div_step
// One combinational restoring-division step. The dividend is shifted out of
// the quotient register MSB-first into the partial remainder; the freshly
// produced quotient bit enters at the quotient LSB.
//   i_rem  partial remainder (always < divisor)
//   i_quo  quotient register (remaining dividend bits above produced bits)
//   i_div  divisor magnitude
//   o_rem  next partial remainder
//   o_quo  next quotient register
// -----------------------------------------------------------------------------
module rv32m_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_div,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shifted;
    logic [32:0] w_trial;

    // Since i_rem < i_div, the shifted remainder is below 2*i_div, so a
    // non-negative trial always fits 32 bits and bit 32 is a clean borrow flag.
    assign w_shifted = {i_rem, i_quo[31]};
    assign w_trial   = w_shifted - {1'b0, i_div};

    assign o_rem = w_trial[32] ? w_shifted[31:0] : w_trial[31:0];
    assign o_quo = {i_quo[30:0], ~w_trial[32]};

endmodule

// File: rtl/rv32m_iter_unit.sv
// -----------------------------------------------------------------------------
// rv32m_iter_unit
// Iterative RV32M multiply/divide responder for the EX stage.
// Captures operands on START, runs 32 shift-add or restoring-divide steps on
// operand magnitudes, restores signs in FIX, then pulses READY with OUT.
// Divide-by-zero and signed overflow complete straight from capture.
// Dropping START during CALC or FIX aborts without READY.
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    slave side of rv32m_iter_unit_if (START/M_CNT/RS1/RS2 in,
//          OUT/READY/BUSY out)
// -----------------------------------------------------------------------------
module rv32m_iter_unit
    import rv32m_iter_unit_pkg::*;
#(
    parameter int XLEN  = RV32M_XLEN,
    parameter int STEPS = RV32M_STEPS
) (
    input  logic              CLK,
    input  logic              RST_N,
    rv32m_iter_unit_if.slave  bus
);

    if (XLEN != 32 || STEPS != XLEN) begin : g_bad_cfg
        $error("rv32m_iter_unit supports only XLEN = STEPS = 32");
    end

    localparam int                CNT_W    = $clog2(STEPS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEPS - 1);

    // Registered state and outputs
    state_e             r_state;
    m_op_e              r_op;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {product high, multiplier remaining}. Divide: {remainder, quotient}.
    logic [63:0]        r_acc;
    logic [31:0]        r_opnd;     // multiplicand or divisor magnitude
    logic               r_sign_a;
    logic               r_sign_b;
    logic [31:0]        r_out;
    logic               r_ready;
    logic               r_busy;

    // Capture-side decode
    m_op_e              w_op;
    op_sign_t           w_sgn;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [31:0]        w_special_result;

    // Iteration datapath
    logic [32:0]        w_mul_sum;
    logic [63:0]        w_mul_next;
    logic [31:0]        w_div_rem;
    logic [31:0]        w_div_quo;

    // Fix-up datapath
    logic [63:0]        w_prod_fix;
    logic [31:0]        w_quo_fix;
    logic [31:0]        w_rem_fix;
    logic [31:0]        w_fix_result;

    assign w_op    = m_op_e'(bus.M_CNT);
    assign w_sgn   = op_signs(w_op);
    assign w_neg_a = w_sgn.signed_a & bus.RS1[31];
    assign w_neg_b = w_sgn.signed_b & bus.RS2[31];
    assign w_mag_a = w_neg_a ? -bus.RS1 : bus.RS1;
    assign w_mag_b = w_neg_b ? -bus.RS2 : bus.RS2;

    assign w_div_zero = op_is_div(w_op) && (bus.RS2 == 32'd0);
    assign w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM))
                        && (bus.RS1 == 32'h8000_0000) && (bus.RS2 == 32'hFFFF_FFFF);

    // Divide by zero: quotient all-ones, remainder is the dividend.
    // Signed overflow: quotient is the dividend itself, remainder zero.
    assign w_special_result = w_div_zero
        ? (((w_op == OP_DIV) || (w_op == OP_DIVU)) ? 32'hFFFF_FFFF : bus.RS1)
        : ((w_op == OP_DIV) ? 32'h8000_0000 : 32'd0);

    // Shift-add step: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    rv32m_div_step u_div_step (
        .i_rem (r_acc[63:32]),
        .i_quo (r_acc[31:0]),
        .i_div (r_opnd),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // For unsigned operands the captured signs are zero, so these reduce to
    // pass-through without looking at the opcode.
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem_fix  = r_sign_a ? -r_acc[63:32] : r_acc[63:32];

    always_comb begin
        // NOTE: every path assigns a default first so no latch is inferred.
        w_fix_result = w_prod_fix[31:0];
        unique case (r_op)
            OP_MUL:                        w_fix_result = w_prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_result = w_prod_fix[63:32];
            OP_DIV, OP_DIVU:               w_fix_result = w_quo_fix;
            OP_REM, OP_REMU:               w_fix_result = w_rem_fix;
            default:                       w_fix_result = w_prod_fix[31:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: datapath registers are reset as well, so OUT reads zero
            // after reset and no stale operand survives an abort.
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_out    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_op     <= w_op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_cnt    <= '0;
                        if (w_div_zero || w_div_ovf) begin
                            r_out   <= w_special_result;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Multiply keeps the multiplier in the low half;
                            // divide starts with remainder 0, dividend low.
                            r_acc   <= {32'd0, op_is_div(w_op) ? w_mag_a : w_mag_b};
                            r_opnd  <= op_is_div(w_op) ? w_mag_b : w_mag_a;
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.START) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= op_is_div(r_op) ? {w_div_rem, w_div_quo} : w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (!bus.START) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_out   <= w_fix_result;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // START is ignored here so a held request is not re-served
                    // before EX has advanced.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.OUT   = r_out;
    assign bus.READY = r_ready;
    assign bus.BUSY  = r_busy;

endmodule

// File: tb/tb_rv32m_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_rv32m_iter_unit
// Scoreboard bench for rv32m_iter_unit: each request pushes its modelled
// result, a negedge monitor pops and compares on every READY pulse; the driver
// checks latency and BUSY per request.
// -----------------------------------------------------------------------------
module tb_rv32m_iter_unit;
    import rv32m_iter_unit_pkg::*;

    logic clk;
    logic rst_n;

    rv32m_iter_unit_if bus ();

    rv32m_iter_unit #(
        .XLEN  (32),
        .STEPS (32)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          n_ready;
    int          n_pushed;
    logic [31:0] sb_q[$];
    logic [31:0] last_out;
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_special(input m_op_e op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    function automatic logic [31:0] model(input m_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_MUL:    begin p = ua * ub; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard monitor: every READY pulse must match the oldest request.
    always @(negedge clk) begin
        if (rst_n && bus.READY === 1'b1) begin
            n_ready++;
            if (sb_q.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("out", bus.OUT, mon_exp);
            end
        end
    end

    // One request. Cycle 0 is the cycle in which START is first sampled high.
    task automatic run_op(input m_op_e op, input logic [31:0] a, input logic [31:0] b, input bit keep);
        int          lat;
        int          exp_lat;
        int          busy_err;
        bit          seen;
        logic [31:0] e;
        e       = model(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : 34;
        sb_q.push_back(e);
        n_pushed++;
        last_out = e;
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        bus.M_CNT = op;
        bus.RS1   = a;
        bus.RS2   = b;
        lat       = 0;
        seen      = 1'b0;
        busy_err  = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (bus.BUSY !== ((exp_lat == 34) && (lat >= 1) && (lat <= 33))) busy_err++;
            if (bus.READY === 1'b1) seen = 1'b1;
            else                    lat++;
        end
        check("latency", seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        check("busy", 32'(busy_err), 32'd0);
        if (!seen) begin
            void'(sb_q.pop_back());
            n_pushed--;
        end
        if (!keep) bus.START = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        m_op_e       rop;
        n_tests  = 0;
        n_fail   = 0;
        n_ready  = 0;
        n_pushed = 0;
        last_out = 32'd0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.M_CNT = 3'b000;
        bus.RS1   = 32'd0;
        bus.RS2   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_out",   bus.OUT,          32'd0);
        check("rst_ready", 32'(bus.READY),   32'd0);
        check("rst_busy",  32'(bus.BUSY),    32'd0);
        rst_n = 1'b1;

        // Multiply group, including sign corners
        run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0);
        run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op(OP_MULH,   32'hFFFF_FFF0,  32'd5,         1'b0);

        // Divide group
        run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(OP_DIVU,   32'd100,        32'd7,         1'b0);
        run_op(OP_REMU,   32'd100,        32'd7,         1'b0);
        run_op(OP_DIV,    32'h8000_0000,  32'd2,         1'b0);

        // Early-exit corner cases
        run_op(OP_DIV,    32'd5,          32'd0,         1'b0);
        run_op(OP_REMU,   32'd5,          32'd0,         1'b0);
        run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 1'b0);

        // Abort: START high for cycles 0..9 of a DIV, low from cycle 10
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        bus.M_CNT = OP_DIV;
        bus.RS1   = 32'd1000;
        bus.RS2   = 32'd3;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_out",  bus.OUT,       last_out);
        repeat (40) @(negedge clk);
        check("abort_out_hold", bus.OUT, last_out);
        run_op(OP_MUL, 32'd3, 32'd4, 1'b0);

        // Back-to-back with START held across both requests
        run_op(OP_MUL, 32'd2, 32'd3, 1'b1);
        run_op(OP_MUL, 32'd4, 32'd5, 1'b0);

        // Random mix, some with small or zero divisors
        for (int i = 0; i < 10; i++) begin
            rop = m_op_e'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            run_op(rop, ra, rb, 1'b0);
        end

        // Reset asserted mid-CALC of a MUL: immediate abort, OUT cleared
        @(posedge clk);
        #1;
        bus.START = 1'b1;
        bus.M_CNT = OP_MUL;
        bus.RS1   = 32'd9;
        bus.RS2   = 32'd9;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.READY), 32'd0);
        check("midrst_out",   bus.OUT,        32'd0);
        check("midrst_busy",  32'(bus.BUSY),  32'd0);
        bus.START = 1'b0;
        last_out  = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        repeat (3) @(negedge clk);
        check("ready_count", 32'(n_ready),     32'(n_pushed));
        check("sb_empty",    32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
